// File: rtl/placar_pkg.sv
// Shared types and segment helpers for the placar_seq scoreboard driver.
package placar_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        WRITE
    } state_t;

    // Active-low gfedcba pattern for a BCD nibble; non-decimal codes are blank.
    function automatic logic [6:0] seg7(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0011000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // 10**n, used for the overflow threshold of a DIGITS-wide display.
    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/placar_seq_seg7_digit.sv
// One seven-segment digit: BCD nibble to active-low segments with blanking.
module seg7_digit
    import placar_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the decoded pattern.
    always_comb begin
        seg = blank ? SEG_BLANK : seg7(nibble);
    end

endmodule

// File: rtl/placar_seq.sv
// Sequential scoreboard driver: round-robin binary-to-BCD conversion of
// CHANNELS scores onto registered active-low seven-segment fields.
module placar_seq
    import placar_pkg::*;
#(
    parameter int unsigned W        = 10,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned BLANK_LZ = 1,
    localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*W-1:0]        score,
    output logic [CHANNELS*DIGITS*7-1:0] hex,
    output logic                         busy,
    output logic                         done,
    output logic [CW-1:0]                done_ch
);

    localparam int unsigned BW    = 4 * DIGITS;
    localparam int unsigned NW    = $clog2(W + 1);
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    state_t                state, state_nx;
    logic [CHANNELS*W-1:0] score_q;
    logic [W-1:0]          last [CHANNELS];
    logic [CHANNELS-1:0]   pend;
    logic [CHANNELS-1:0]   dirty;
    logic [CW-1:0]         rr_ptr;
    logic [CW-1:0]         ch;
    logic [CW-1:0]         sel;
    logic                  found;
    logic [W-1:0]          cur;
    logic [W-1:0]          snap;
    logic [W-1:0]          bin;
    logic [BW-1:0]         bcd;
    logic [BW-2:0]         bcd_adj;
    logic [NW-1:0]         cnt;
    logic                  ovf;
    logic [DIGITS-1:0]     blank;
    logic [DIGITS*7-1:0]   digit_seg;
    logic [DIGITS*7-1:0]   field;

    assign cur  = score_q[ch*W +: W];
    assign busy = (state != IDLE);

    // A channel needs service when its sampled score differs from the last
    // converted value, or when it has not been converted since reset.
    always_comb begin
        dirty = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            dirty[c] = pend[c] | (score_q[c*W +: W] != last[c]);
        end
    end

    // Round-robin pick: first dirty channel at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            idx = (int'(rr_ptr) + i) % CHANNELS;
            if (!found && dirty[idx]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
    end

    // Add-3 correction; the top nibble keeps only the bits that survive the
    // following left shift, since its carry out is discarded.
    always_comb begin
        logic [3:0] nib;
        bcd_adj = '0;
        nib     = '0;
        for (int unsigned d = 0; d + 1 < DIGITS; d++) begin
            nib = bcd[4*d +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_adj[4*d +: 4] = nib;
        end
        nib = bcd[BW-1 -: 4];
        if (nib >= 4'd5) nib = nib + 4'd3;
        bcd_adj[BW-2 -: 3] = nib[2:0];
    end

    // Leading-zero blanking, scanned from the most significant digit down.
    always_comb begin
        logic seen;
        int unsigned d;
        blank = '0;
        seen  = 1'b0;
        d     = 0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            d = DIGITS - 1 - i;
            if (bcd[4*d +: 4] != 4'd0) seen = 1'b1;
            blank[d] = (BLANK_LZ != 0) && (d != 0) && !seen;
        end
    end

    for (genvar gd = 0; gd < DIGITS; gd++) begin : g_digit
        seg7_digit u_digit (
            .nibble (bcd[4*gd +: 4]),
            .blank  (blank[gd]),
            .seg    (digit_seg[7*gd +: 7])
        );
    end

    assign field = ovf ? {DIGITS{SEG_DASH}} : digit_seg;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (found) state_nx = LOAD;
            LOAD:    state_nx = SHIFT;
            SHIFT:   if (cnt == NW'(W - 1)) state_nx = WRITE;
            WRITE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Input sampling, conversion datapath and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) last[c] <= '0;
            pend    <= '1;
            rr_ptr  <= '0;
            ch      <= '0;
            snap    <= '0;
            bin     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            hex     <= '1;
            done    <= 1'b0;
            done_ch <= '0;
        end else begin
            score_q <= score;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) ch <= sel;
                end
                LOAD: begin
                    snap <= cur;
                    bin  <= cur;
                    bcd  <= '0;
                    cnt  <= '0;
                    ovf  <= (64'(cur) >= LIMIT);
                end
                SHIFT: begin
                    bcd <= {bcd_adj, bin[W-1]};
                    bin <= bin << 1;
                    cnt <= cnt + 1'b1;
                end
                WRITE: begin
                    hex[ch*DIGITS*7 +: DIGITS*7] <= field;
                    last[ch] <= snap;
                    pend[ch] <= 1'b0;
                    rr_ptr   <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
                    done     <= 1'b1;
                    done_ch  <= ch;
                end
                default: ;
            endcase
        end
    end

endmodule
